// File: rtl/pulse_interval_meter.sv
// pulse_interval_meter: measures clk cycles between successive rising edges of an
// asynchronous input, reports each interval with a one-cycle strobe, and flags a
// stalled source with a timeout level.
module pulse_interval_meter #(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_in_data,
    output logic [W-1:0] o_interval,
    output logic         o_valid,
    output logic         o_overflow,
    output logic         o_timeout,
    output logic         o_armed
);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    localparam logic [W:0]   TimeoutVal = (W+1)'(TIMEOUT);
    localparam logic [W-1:0] CountMax   = {W{1'b1}};
    localparam logic         TimeoutEn  = (TIMEOUT != 0);

    state_e       r_state;
    state_e       w_state_next;
    logic         r_s1;
    logic         r_s2;
    logic         r_s3;
    logic [W-1:0] r_count;

    logic         w_det;
    logic [W:0]   w_count_inc;
    logic         w_tmo_hit;
    logic         w_load;
    logic         w_report;
    logic         w_expire;

    assign w_det       = r_s2 & ~r_s3;
    // One bit wider so the carry out of count+1 marks a saturated interval.
    assign w_count_inc = {1'b0, r_count} + (W+1)'(1);
    assign w_tmo_hit   = TimeoutEn && (w_count_inc == TimeoutVal);

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_in_data;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: arm on first edge, drop back to idle on timeout; an edge beats a timeout.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_det) begin
                    w_state_next = StMeasure;
                end
            end
            StMeasure: begin
                if (!w_det && w_tmo_hit) begin
                    w_state_next = StIdle;
                end
            end
        endcase
    end

    // Action decode: arming load, interval report, or timeout expiry.
    always_comb begin
        w_load   = 1'b0;
        w_report = 1'b0;
        w_expire = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_load = w_det;
            end
            StMeasure: begin
                w_report = w_det;
                w_expire = !w_det && w_tmo_hit;
            end
        endcase
    end

    // Interval counter: restarts on every edge, saturates instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (w_load || w_report) begin
            r_count <= '0;
        end else if (r_state == StMeasure && r_count != CountMax) begin
            r_count <= w_count_inc[W-1:0];
        end
    end

    // Registered outputs; interval/overflow only move together with valid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_interval <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
            o_timeout  <= 1'b0;
            o_armed    <= 1'b0;
        end else begin
            o_valid <= w_report;
            if (w_report) begin
                o_interval <= w_count_inc[W] ? CountMax : w_count_inc[W-1:0];
                o_overflow <= w_count_inc[W];
            end
            if (w_det) begin
                o_timeout <= 1'b0;
            end else if (w_expire) begin
                o_timeout <= 1'b1;
            end
            o_armed <= (w_state_next == StMeasure);
        end
    end

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Bench for pulse_interval_meter: two instances (default and W=4/TIMEOUT=0) share
// one stimulus; an edge-time reference model is checked every cycle, plus literal
// expectations for the directed scenarios.
module tb_pulse_interval_meter;

    logic       clk;
    logic       rst;
    logic       in_data;

    logic [7:0] interval_a;
    logic       valid_a, overflow_a, timeout_a, armed_a;
    logic [3:0] interval_b;
    logic       valid_b, overflow_b, timeout_b, armed_b;

    int checks = 0;
    int errors = 0;

    pulse_interval_meter #(.W(8), .TIMEOUT(200)) u_dut_a (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_in_data  (in_data),
        .o_interval (interval_a),
        .o_valid    (valid_a),
        .o_overflow (overflow_a),
        .o_timeout  (timeout_a),
        .o_armed    (armed_a)
    );

    pulse_interval_meter #(.W(4), .TIMEOUT(0)) u_dut_b (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_in_data  (in_data),
        .o_interval (interval_b),
        .o_valid    (valid_b),
        .o_overflow (overflow_b),
        .o_timeout  (timeout_b),
        .o_armed    (armed_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: works on edge times. A rising input seen at posedge t-2
    // (and low at t-3, no reset at t-1) is a detection acting at posedge t.
    int  m_max[2] = '{255, 15};
    int  m_tmo[2] = '{200, 0};
    bit  m_armed[2], m_valid[2], m_ov[2], m_to[2];
    int  m_interval[2], m_last[2];
    bit  h1 = 0, h2 = 0, h3 = 0, r1 = 1;
    int  t = 0;
    bit  started = 0;
    bit  det;
    int  d;

    always @(posedge clk) begin
        det = !r1 && h2 && !h3;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_armed[i] = 0; m_valid[i] = 0; m_ov[i] = 0; m_to[i] = 0;
                m_interval[i] = 0;
            end else begin
                m_valid[i] = 0;
                if (det) begin
                    if (m_armed[i]) begin
                        d = t - m_last[i];
                        m_valid[i] = 1;
                        m_interval[i] = (d > m_max[i]) ? m_max[i] : d;
                        m_ov[i] = (d > m_max[i]);
                    end
                    m_armed[i] = 1;
                    m_to[i] = 0;
                    m_last[i] = t;
                end else if (m_armed[i] && m_tmo[i] != 0 && t - m_last[i] == m_tmo[i]) begin
                    m_armed[i] = 0;
                    m_to[i] = 1;
                end
            end
        end
        h3 = h2;
        h2 = h1;
        h1 = rst ? 1'b0 : in_data;
        r1 = rst;
        t++;
        started = 1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            cmp("a_valid",    int'(valid_a),    int'(m_valid[0]));
            cmp("a_interval", int'(interval_a), m_interval[0]);
            cmp("a_overflow", int'(overflow_a), int'(m_ov[0]));
            cmp("a_timeout",  int'(timeout_a),  int'(m_to[0]));
            cmp("a_armed",    int'(armed_a),    int'(m_armed[0]));
            cmp("b_valid",    int'(valid_b),    int'(m_valid[1]));
            cmp("b_interval", int'(interval_b), m_interval[1]);
            cmp("b_overflow", int'(overflow_b), int'(m_ov[1]));
            cmp("b_timeout",  int'(timeout_b),  int'(m_to[1]));
            cmp("b_armed",    int'(armed_b),    int'(m_armed[1]));
        end
    end

    int p;
    int plist[5] = '{50, 20, 3, 1, 0};

    initial begin
        rst = 1'b1;
        in_data = 1'b0;
        cyc(3);
        cmp("rst_interval", int'(interval_a), 0);
        cmp("rst_armed", int'(armed_a), 0);
        cmp("rst_valid", int'(valid_a), 0);
        rst = 1'b0;
        cyc(5);

        // Three edges 10 apart: first only arms.
        in_data = 1; cyc(1); in_data = 0; cyc(2);
        cmp("s1_armed", int'(armed_a), 1);
        cmp("s1_first_novalid", int'(valid_a), 0);
        cyc(7);
        in_data = 1; cyc(1); in_data = 0; cyc(2);
        cmp("s1_valid2", int'(valid_a), 1);
        cmp("s1_interval2", int'(interval_a), 10);
        cmp("s1_overflow2", int'(overflow_a), 0);
        cyc(7);
        in_data = 1; cyc(1); in_data = 0; cyc(2);
        cmp("s1_valid3", int'(valid_a), 1);
        cmp("s1_interval3", int'(interval_a), 10);

        // Toggle every cycle: interval 2 on alternate cycles.
        for (int i = 0; i < 12; i++) begin
            in_data = (i % 2 == 0);
            cyc(1);
        end
        cmp("s2_gap_novalid", int'(valid_a), 0);
        cyc(1);
        cmp("s2_valid", int'(valid_a), 1);
        cmp("s2_interval", int'(interval_a), 2);

        // Let it time out, then arm and observe the 200-cycle timeout.
        cyc(250);
        in_data = 1; cyc(1); in_data = 0; cyc(2);
        cmp("s3_armed", int'(armed_a), 1);
        cmp("s3_arm_novalid", int'(valid_a), 0);
        cyc(199);
        cmp("s3_to_early", int'(timeout_a), 0);
        cyc(1);
        cmp("s3_timeout", int'(timeout_a), 1);
        cmp("s3_disarmed", int'(armed_a), 0);
        in_data = 1; cyc(1); in_data = 0; cyc(2);
        cmp("s3_to_clear", int'(timeout_a), 0);
        cmp("s3_rearm", int'(armed_a), 1);
        cmp("s3_rearm_novalid", int'(valid_a), 0);
        cyc(2);
        in_data = 1; cyc(1); in_data = 0; cyc(2);
        cmp("s3_interval5", int'(interval_a), 5);

        // Edges exactly 200 apart: detection beats timeout.
        cyc(197);
        in_data = 1; cyc(1); in_data = 0; cyc(2);
        cmp("s4_valid200", int'(valid_a), 1);
        cmp("s4_interval200", int'(interval_a), 200);
        cmp("s4_no_timeout", int'(timeout_a), 0);
        // 201 apart: timeout first.
        cyc(198);
        in_data = 1; cyc(1); in_data = 0; cyc(1);
        cmp("s4_timeout201", int'(timeout_a), 1);
        cmp("s4_novalid201", int'(valid_a), 0);
        cyc(1);
        cmp("s4_rearm_armed", int'(armed_a), 1);
        cmp("s4_rearm_novalid", int'(valid_a), 0);

        // Saturation on the narrow instance.
        cyc(17);
        in_data = 1; cyc(1); in_data = 0; cyc(2);
        cmp("s5_b_interval", int'(interval_b), 15);
        cmp("s5_b_overflow", int'(overflow_b), 1);
        cmp("s5_a_interval", int'(interval_a), 20);
        cyc(4);
        in_data = 1; cyc(1); in_data = 0; cyc(2);
        cmp("s5_b_interval7", int'(interval_b), 7);
        cmp("s5_b_overflow0", int'(overflow_b), 0);

        // Reset mid-measurement: next edge only re-arms.
        rst = 1; cyc(1); rst = 0;
        cmp("s6_rst_interval", int'(interval_a), 0);
        cmp("s6_rst_armed", int'(armed_a), 0);
        cyc(5);
        in_data = 1; cyc(1); in_data = 0; cyc(2);
        cmp("s6_novalid", int'(valid_a), 0);
        cmp("s6_armed", int'(armed_a), 1);
        cmp("s6_interval0", int'(interval_a), 0);

        // Input held high across reset release arms two cycles later.
        in_data = 1; rst = 1; cyc(2);
        rst = 0; cyc(2);
        cmp("s6_hold_notyet", int'(armed_a), 0);
        cyc(1);
        cmp("s6_hold_armed", int'(armed_a), 1);
        in_data = 0;
        cyc(3);

        // Randomized traffic with varying edge density and occasional resets.
        for (int blk = 0; blk < 20; blk++) begin
            p = plist[$urandom_range(0, 4)];
            for (int c = 0; c < 200; c++) begin
                in_data = ($urandom_range(0, 99) < p);
                rst = ($urandom_range(0, 599) == 0);
                cyc(1);
            end
        end
        rst = 0;
        in_data = 0;
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
